// File: rtl/pcie_us_msi_pkg.sv
// Shared types and helpers for the UltraScale PCIe MSI interrupt scheduler.
// State encoding, fail counter width and the multiple-message-enable mask.
`timescale 1ns/1ps
package pcie_us_msi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } msi_state_e;

    localparam int FAIL_CNT_W = 16;

    // Allowed vectors = 2^mm; encodings 5..7 all mean the full 32.
    function automatic logic [31:0] mmen_mask(input logic [2:0] mm);
        logic [31:0] m;
        if (mm >= 3'd5) begin
            m = '1;
        end else begin
            m = (32'd1 << (6'd1 << mm)) - 32'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pcie_msi_rr_select.sv
// Combinational round-robin picker: first requester strictly after last_grant, wrapping.
// Zero latency; no backpressure, the caller decides whether to consume the grant.
`timescale 1ns/1ps
module pcie_msi_rr_select #(
    parameter int N    = 32,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last_grant,
    output logic            grant_vld,
    output logic [IDXW-1:0] grant_idx,
    output logic [N-1:0]    grant_oh
);

    int               pos;
    logic [IDXW-1:0]  cand;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        pos       = 0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            pos = int'(last_grant) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = IDXW'(pos);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/pcie_us_msi_sched.sv
// MSI scheduler: latches irq_in into pending, issues one vector round-robin as a 1-cycle pulse
// (irq to pulse 2 cycles), then holds off further issues until sent/fail/timeout re-queues or retires it.
`timescale 1ns/1ps
module pcie_us_msi_sched
    import pcie_us_msi_pkg::*;
#(
    parameter int MSI_COUNT     = 32,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MSI_COUNT-1:0]  irq_in,
    input  logic [3:0]            cfg_interrupt_msi_enable,
    input  logic [11:0]           cfg_interrupt_msi_mmenable,
    output logic [31:0]           cfg_interrupt_msi_int,
    input  logic                  cfg_interrupt_msi_sent,
    input  logic                  cfg_interrupt_msi_fail,
    output logic [MSI_COUNT-1:0]  pending,
    output logic                  busy,
    output logic [FAIL_CNT_W-1:0] fail_count
);

    localparam int IDXW = (MSI_COUNT > 1) ? $clog2(MSI_COUNT) : 1;

    msi_state_e              state_q, state_d;
    logic [MSI_COUNT-1:0]    pending_q, pending_d;
    logic [31:0]             int_q, int_d;
    logic                    busy_q, busy_d;
    logic [IDXW-1:0]         last_q, last_d;
    logic [IDXW-1:0]         inflight_q, inflight_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    logic [31:0]             mm_mask;
    logic [MSI_COUNT-1:0]    eligible;
    logic [MSI_COUNT-1:0]    issue_clear;
    logic [MSI_COUNT-1:0]    requeue;
    logic                    sel_vld;
    logic [IDXW-1:0]         sel_idx;
    logic [MSI_COUNT-1:0]    sel_oh;
    logic                    unused_cfg;

    // Only PF0 is served; the other PFs' enable fields are ignored.
    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    assign mm_mask  = mmen_mask(cfg_interrupt_msi_mmenable[2:0]);
    assign eligible = pending_q
                    & {MSI_COUNT{cfg_interrupt_msi_enable[0]}}
                    & mm_mask[MSI_COUNT-1:0];

    pcie_msi_rr_select #(
        .N    (MSI_COUNT),
        .IDXW (IDXW)
    ) u_rr (
        .req        (eligible),
        .last_grant (last_q),
        .grant_vld  (sel_vld),
        .grant_idx  (sel_idx),
        .grant_oh   (sel_oh)
    );

    always_comb begin
        state_d     = state_q;
        int_d       = '0;
        busy_d      = busy_q;
        last_d      = last_q;
        inflight_d  = inflight_q;
        tmo_d       = tmo_q;
        fail_cnt_d  = fail_cnt_q;
        issue_clear = '0;
        requeue     = '0;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    int_d[MSI_COUNT-1:0] = sel_oh;
                    issue_clear          = sel_oh;
                    last_d               = sel_idx;
                    inflight_d           = sel_idx;
                    busy_d               = 1'b1;
                    state_d              = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
                // A simultaneous sent+fail is treated as a failure.
                if (cfg_interrupt_msi_fail || (tmo_q == '1)) begin
                    requeue[inflight_q] = 1'b1;
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cfg_interrupt_msi_sent) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        pending_d = ((pending_q | irq_in) & ~issue_clear) | requeue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            int_q      <= '0;
            busy_q     <= 1'b0;
            last_q     <= IDXW'(MSI_COUNT - 1);
            inflight_q <= '0;
            tmo_q      <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            int_q      <= int_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            inflight_q <= inflight_d;
            tmo_q      <= tmo_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign cfg_interrupt_msi_int = int_q;
    assign pending               = pending_q;
    assign busy                  = busy_q;
    assign fail_count            = fail_cnt_q;

endmodule
